// File: rtl/multicycle_ctrl.sv
// Main-FSM controller for the multicycle RV32I-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath selects and strobes.
module multicycle_ctrl #(
  parameter int NBITS_CNT = 8,
  parameter int STATE_W   = 4
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic                 RegWrite,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic [STATE_W-1:0]   state_o,
  output logic [NBITS_CNT-1:0] instr_count,
  output logic                 illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, HALT
  } state_t;

  state_t state, state_next;
  logic   retire;
  logic   pc_update, ir_write, reg_write, mem_write;
  logic [2:0] funct_alu;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else if (en) begin
      state <= state_next;
      if (retire)
        instr_count <= instr_count + NBITS_CNT'(1);
      if (state == DECODE && state_next == HALT)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:    state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = HALT;
        endcase
      end
      MEMADR:   state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = MEMWB;
      EXECUTER, EXECUTEI, JAL: state_next = ALUWB;
      MEMWB, MEMWRITE, ALUWB, BEQ: state_next = FETCH;
      HALT:     state_next = HALT;
      default:  state_next = FETCH;
    endcase
  end

  assign retire = (state == MEMWB) || (state == MEMWRITE) ||
                  (state == ALUWB) || (state == BEQ);

  // Only R-type distinguishes sub from add; addi with funct7b5 set is still add.
  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    AdrSrc     = 1'b0;
    Branch     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_alu;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu;
      end
      ALUWB:    reg_write = 1'b1;
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        Branch     = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // A frozen step (en=0) must not commit anything, so every strobe is gated.
  assign PCWrite  = en & (pc_update | (Branch & zero));
  assign IRWrite  = en & ir_write;
  assign RegWrite = en & reg_write;
  assign MemWrite = en & mem_write;
  assign MemtoReg = (ResultSrc == 2'b01);
  assign state_o  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model with
// randomized operands/enables, plus directed scenarios for each instruction class.
module tb_multicycle_ctrl;

  logic       clk_2, reset_n, en, funct7b5, zero;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Branch, MemtoReg, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;
  logic [7:0] instr_count;

  multicycle_ctrl #(.NBITS_CNT(8), .STATE_W(4)) dut (
    .clk_2(clk_2), .reset_n(reset_n), .en(en), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .Branch(Branch),
    .MemtoReg(MemtoReg), .state_o(state_o), .instr_count(instr_count),
    .illegal(illegal)
  );

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  // clock/reset
  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  wire [30:0] obs = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                     ALUSrcB, ImmSrc, ALUControl, RegWrite, Branch, MemtoReg,
                     instr_count, illegal};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an instruction is a list of states to visit after FETCH.
  int         ms;
  int         pend[$];
  logic [7:0] m_cnt;
  logic       m_ill;
  logic [30:0] e;

  function automatic void build_path(logic [6:0] o);
    pend.delete();
    case (o)
      LW:      pend = '{1, 2, 3, 4};
      SW:      pend = '{1, 2, 5};
      RT:      pend = '{1, 6, 8};
      IT:      pend = '{1, 7, 8};
      BQ:      pend = '{1, 9};
      JL:      pend = '{1, 10, 8};
      default: pend = '{1, 11};
    endcase
  endfunction

  function automatic void model_step();
    if (!en) return;
    if (ms == 0) begin
      build_path(op);
      ms = pend.pop_front();
    end else if (ms == 11) begin
      ms = 11;
    end else if (pend.size() == 0) begin
      ms = 0;
      m_cnt = m_cnt + 8'd1;
    end else begin
      ms = pend.pop_front();
      if (ms == 11) m_ill = 1'b1;
    end
  endfunction

  function automatic logic [2:0] model_alu();
    case (funct3)
      3'b000:  return (op == RT && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [30:0] model_out();
    logic pcu, adr, mw, irw, rw, br, pcw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    {pcu, adr, mw, irw, rw, br} = '0;
    {rs, sa, sb} = '0;
    alu = 3'b000;
    case (ms)
      0:  begin irw = 1; sb = 2; rs = 2; pcu = 1; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; alu = model_alu(); end
      7:  begin sa = 2; sb = 1; alu = model_alu(); end
      8:  rw = 1;
      9:  begin sa = 2; alu = 3'b001; br = 1; end
      10: begin sa = 1; sb = 2; pcu = 1; end
      default: ;
    endcase
    imm = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
    pcw = en && (pcu || (br && zero));
    if (!en) begin irw = 0; rw = 0; mw = 0; end
    return {4'(ms), pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, br, (rs == 2'd1),
            m_cnt, m_ill};
  endfunction

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ms = 0; pend.delete(); m_cnt = 8'd0; m_ill = 1'b0;
    @(posedge clk_2);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_instr(logic [6:0] o, logic [2:0] f3, logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; zero = 1'b0;
    set_instr(RT, 3'b000, 1'b1);
    ms = 0; pend.delete(); m_cnt = 8'd0; m_ill = 1'b0;
    #1;
    n_checks++;
    if (obs !== model_out()) $display("FAIL reset_async got %h exp %h", obs, model_out());
    else n_pass++;
    @(posedge clk_2); #1;
    n_checks++;
    if (state_o !== 4'd0 || instr_count !== 8'd0 || illegal !== 1'b0)
      $display("FAIL reset_hold state=%0d cnt=%0d ill=%b exp 0/0/0", state_o, instr_count, illegal);
    else n_pass++;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (obs !== model_out()) $display("FAIL reset_release got %h exp %h", obs, model_out());
    else n_pass++;
  endtask

  task automatic test_rtype_sub();
    set_instr(RT, 3'b000, 1'b1); en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1; e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL rtype c%0d got %h exp %h", c, obs, e);
      else n_pass++;
      if (c == 2) begin
        n_checks++;
        if (state_o !== 4'd6 || ALUControl !== 3'b001)
          $display("FAIL rtype_sub state=%0d alu=%b exp 6/001", state_o, ALUControl);
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (state_o !== 4'd0 || instr_count !== 8'd1)
      $display("FAIL rtype_retire state=%0d cnt=%0d exp 0/1", state_o, instr_count);
    else n_pass++;
  endtask

  task automatic test_mem();
    en = 1'b1;
    set_instr(LW, 3'b010, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1; e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL lw c%0d got %h exp %h", c, obs, e);
      else n_pass++;
      tick();
    end
    set_instr(SW, 3'b010, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1; e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL sw c%0d got %h exp %h", c, obs, e);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (state_o !== 4'd0 || instr_count !== m_cnt)
      $display("FAIL mem_retire state=%0d cnt=%0d exp 0/%0d", state_o, instr_count, m_cnt);
    else n_pass++;
  endtask

  task automatic test_beq_jal();
    en = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      set_instr(BQ, 3'b000, 1'b0);
      zero = z[0];
      for (int c = 0; c < 3; c++) begin
        #1; e = model_out();
        n_checks++;
        if (obs !== e) $display("FAIL beq_z%0d c%0d got %h exp %h", z, c, obs, e);
        else n_pass++;
        if (c == 2) begin
          n_checks++;
          if (PCWrite !== z[0] || ImmSrc !== 2'b10)
            $display("FAIL beq_pcwrite z=%0d pcw=%b imm=%b exp %b/10", z, PCWrite, ImmSrc, z[0]);
          else n_pass++;
        end
        tick();
      end
    end
    zero = 1'b0;
    set_instr(JL, 3'b000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1; e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL jal c%0d got %h exp %h", c, obs, e);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_en_hold();
    en = 1'b1;
    set_instr(SW, 3'b010, 1'b0);
    repeat (3) tick();
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (state_o !== 4'd5 || MemWrite !== 1'b0 || AdrSrc !== 1'b1)
        $display("FAIL en_hold c%0d state=%0d mw=%b adr=%b exp 5/0/1", c, state_o, MemWrite, AdrSrc);
      else n_pass++;
      tick();
    end
    en = 1'b1;
    #1; e = model_out();
    n_checks++;
    if (obs !== e || MemWrite !== 1'b1) $display("FAIL en_resume got %h exp %h", obs, e);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    ops = '{LW, SW, RT, IT, BQ, JL};
    for (int c = 0; c < 600; c++) begin
      if (ms == 0)
        set_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      en   = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
      #1; e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL random c%0d op=%b got %h exp %h", c, op, obs, e);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1; zero = 1'b0;
    set_instr(IT, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    for (int c = 0; c < 256 * 4; c++) begin
      #1; e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL wrap c%0d got %h exp %h", c, obs, e);
      else n_pass++;
      if (c == 255 * 4) begin
        n_checks++;
        if (instr_count !== 8'd255) $display("FAIL wrap_255 cnt=%0d exp 255", instr_count);
        else n_pass++;
      end
      tick();
    end
    #1;
    n_checks++;
    if (instr_count !== 8'd0 || state_o !== 4'd0)
      $display("FAIL wrap_zero cnt=%0d state=%0d exp 0/0", instr_count, state_o);
    else n_pass++;
  endtask

  task automatic test_illegal();
    en = 1'b1;
    set_instr(7'b1111111, 3'b000, 1'b0);
    for (int c = 0; c < 14; c++) begin
      en   = ($urandom_range(0, 4) != 0);
      zero = 1'($urandom_range(0, 1));
      #1; e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL illegal c%0d got %h exp %h", c, obs, e);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (state_o !== 4'd11 || illegal !== 1'b1 || PCWrite !== 1'b0 || IRWrite !== 1'b0 ||
        RegWrite !== 1'b0 || MemWrite !== 1'b0)
      $display("FAIL halt state=%0d ill=%b exp 11/1 strobes 0", state_o, illegal);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (state_o !== 4'd0 || illegal !== 1'b0 || instr_count !== 8'd0)
      $display("FAIL async_reset state=%0d ill=%b cnt=%0d exp 0/0/0", state_o, illegal, instr_count);
    else n_pass++;
    ms = 0; pend.delete(); m_cnt = 8'd0; m_ill = 1'b0;
    @(posedge clk_2); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    en = 1'b1; zero = 1'b1;
    set_instr(RT, 3'b111, 1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c == 4) set_instr(IT, 3'b110, 1'b1);
      #1; e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL b2b c%0d got %h exp %h", c, obs, e);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (instr_count !== 8'd2) $display("FAIL b2b_count cnt=%0d exp 2", instr_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_mem();
    test_beq_jal();
    test_en_hold();
    test_random();
    test_illegal();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main-FSM controller that sequences the multicycle RV32I-subset datapath whose state is shown on the board LCD (pc, SrcA, SrcB, ALUResult, Result, MemWrite, Branch, MemtoReg, RegWrite).
- Decodes opcode/funct fields and steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and write strobe.
- Exports the FSM state and a retired-instruction count for the LCD/LED debug display.

Parameters:
- NBITS_CNT, 8, width of retired-instruction counter.
- STATE_W, 4, width of state encoding.

Ports:
- clk_2  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  step enable (tied to a SWI bit); 0 freezes the FSM.
- op  input  7  instr[6:0].
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- zero  input  1  ALU zero flag.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  data memory write strobe.
- IRWrite  output  1  instruction register / OldPC enable.
- ResultSrc  output  2  result select: 00 ALUOut, 01 ReadData, 10 ALUResult.
- ALUSrcA  output  2  ALU A select: 00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  output  2  ALU B select: 00 RD2, 01 Imm, 10 constant 4.
- ImmSrc  output  2  immediate type: 00 I, 01 S, 10 B, 11 J.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RegWrite  output  1  register file write strobe.
- Branch  output  1  high in BEQ state (LCD debug).
- MemtoReg  output  1  equals ResultSrc==01 (LCD debug).
- state_o  output  STATE_W  current state.
- instr_count  output  NBITS_CNT  retired instructions, wraps.
- illegal  output  1  sticky unsupported-opcode flag.

Behaviour:
- States: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, HALT 11.
- Reset: while reset_n=0, state=FETCH, instr_count=0, illegal=0. These take effect immediately and asynchronously. Reset mid-instruction aborts it with no strobes.
- Transitions (on posedge clk_2, only when en=1):
  - FETCH→DECODE.
  - DECODE: op 0000011 or 0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; any other op → HALT.
  - MEMADR: lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER, EXECUTEI, JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ → FETCH.
  - HALT is absorbing until reset.
- Moore outputs by state; all strobes and selects not listed are 0:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, funct-decoded op.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct-decoded op.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1.
- PCWrite = PCUpdate | (Branch & zero).
- ImmSrc is combinational from op: sw → 01, beq → 10, jal → 11, else 00.
- ALUControl in funct-decoded states, by funct3:
  - 000: sub only when op=0110011 and funct7b5=1, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3: add.
- en=0: state, counter and flag hold. PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 that cycle. Selects keep their state values.
- instr_count increments by 1 on each en=1 exit from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps from 2^NBITS_CNT-1 to 0.
- illegal is set on the DECODE→HALT transition and cleared only by reset. In HALT all strobes are 0.
- Reset deassertion is used directly; the top level synchronizes reset_n to clk_2.

Test Plan:
- Reset then en=1, op=0110011, funct3=000, funct7b5=1 → states 0,1,6,8,0; ALUControl=001 in EXECUTER; RegWrite=1 only in ALUWB; instr_count=1.
- lw (op=0000011) → states 0,1,2,3,4,0 (5 cycles); AdrSrc=1 in MEMREAD; MemtoReg=1 and RegWrite=1 in MEMWB. sw (op=0100011) → 0,1,2,5,0 with MemWrite=1 only in state 5 and ImmSrc=01.
- beq (op=1100011) with zero=1 → PCWrite=1 in BEQ, ImmSrc=10. With zero=0 → PCWrite=0. Both cases take 3 cycles, and instr_count increments.
- jal (op=1101111) → 0,1,10,8,0; PCWrite=1 in JAL; ImmSrc=11.
- Illegal op=1111111 → HALT (11), illegal=1, strobes stay 0 for 10+ cycles. Assert reset_n=0 mid-HALT → state 0 and illegal=0 immediately, without waiting for a clock edge.
- en=0 held 3 cycles in MEMWRITE → state stays 5, MemWrite=0. 256 retired addi instructions → instr_count wraps to 0.
